// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter: FSM state encoding, the
// "no slave" id and the {master_id, slave_id} packing used on bus_state.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned SLAVE_NONE = 32'd0;

  // Callers truncate the 32-bit result to their own master+slave field width.
  function automatic logic [31:0] pack_bus_state(input logic [31:0] master_id,
                                                 input logic [31:0] slave_id,
                                                 input int unsigned s_id_w);
    return (master_id << s_id_w) | slave_id;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Round-robin request search: the first active request strictly after ptr_i,
// wrapping modulo N, so the master at ptr_i itself is considered last.
module rr_priority_sel #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int         cand;
  logic [W-1:0] cand_idx;

  // Walk the candidates in priority order; the explicit compare keeps the wrap
  // correct when N is not a power of two.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = {W{1'b0}};
    cand     = 32'sd0;
    cand_idx = {W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      cand_idx = W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared serial bus, with an optional hold
// timeout and a one-cycle idle turnaround between consecutive owners.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
  parameter int MAX_HOLD   = 256
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             req_M      [0:NO_MASTERS-1],
  input  logic [S_ID_WIDTH-1:0]            slave_id_M [0:NO_MASTERS-1],
  input  logic                             ready,
  output logic                             grant_M    [0:NO_MASTERS-1],
  output logic                             preempt_M  [0:NO_MASTERS-1],
  output logic [M_ID_WIDTH+S_ID_WIDTH-1:0] bus_state,
  output logic                             req_err
);

  localparam int BS_W = M_ID_WIDTH + S_ID_WIDTH;
  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0]       HOLD_SAT = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0]       HOLD_LIM = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : {HC_W{1'b0}};
  localparam logic [S_ID_WIDTH-1:0] SID_MAX  = S_ID_WIDTH'(NO_SLAVES);
  localparam logic [S_ID_WIDTH-1:0] SID_NONE = S_ID_WIDTH'(SLAVE_NONE);
  localparam logic [M_ID_WIDTH-1:0] RR_RST   = M_ID_WIDTH'(NO_MASTERS - 1);

  arb_state_t                state_q, state_d;
  logic [M_ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HC_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic [NO_MASTERS-1:0]     grant_q, grant_d;
  logic [NO_MASTERS-1:0]     preempt_q, preempt_d;
  logic [BS_W-1:0]           bus_state_q, bus_state_d;
  logic                      req_err_q, req_err_d;

  logic [NO_MASTERS-1:0]     req_vec;
  logic                      sel_found;
  logic [M_ID_WIDTH-1:0]     sel_idx;
  logic [S_ID_WIDTH-1:0]     cand_sid;
  logic                      cand_valid;
  logic [M_ID_WIDTH-1:0]     owner;
  logic                      owner_req;
  logic                      other_req;
  logic                      timeout;

  for (genvar g = 0; g < NO_MASTERS; g++) begin : g_port
    assign req_vec[g]   = req_M[g];
    assign grant_M[g]   = grant_q[g];
    assign preempt_M[g] = preempt_q[g];
  end

  assign bus_state = bus_state_q;
  assign req_err   = req_err_q;

  rr_priority_sel #(
    .N (NO_MASTERS),
    .W (M_ID_WIDTH)
  ) u_sel (
    .req_i   (req_vec),
    .ptr_i   (rr_ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  // Candidate validity, current owner and the timeout preemption condition.
  always_comb begin
    cand_sid   = slave_id_M[sel_idx];
    cand_valid = (cand_sid != SID_NONE) && (cand_sid <= SID_MAX);
    owner      = bus_state_q[BS_W-1 -: M_ID_WIDTH];
    owner_req  = req_vec[owner];
    other_req  = 1'b0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      other_req = other_req | (req_vec[i] & (M_ID_WIDTH'(i) != owner));
    end
    timeout = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LIM) && other_req && ready;
  end

  // State and output registers; reset drops any grant without a release cycle.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      rr_ptr_q    <= RR_RST;
      hold_cnt_q  <= {HC_W{1'b0}};
      grant_q     <= {NO_MASTERS{1'b0}};
      preempt_q   <= {NO_MASTERS{1'b0}};
      bus_state_q <= {BS_W{1'b0}};
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_q     <= grant_d;
      preempt_q   <= preempt_d;
      bus_state_q <= bus_state_d;
      req_err_q   <= req_err_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_found && cand_valid) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req || timeout) begin
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, round-robin pointer and hold counter.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    preempt_d   = {NO_MASTERS{1'b0}};
    bus_state_d = bus_state_q;
    req_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = {NO_MASTERS{1'b0}};
        if (sel_found) begin
          rr_ptr_d = sel_idx;
          if (cand_valid) begin
            grant_d[sel_idx] = 1'b1;
            bus_state_d      = BS_W'(pack_bus_state(32'(sel_idx), 32'(cand_sid), S_ID_WIDTH));
            hold_cnt_d       = {HC_W{1'b0}};
          end else begin
            req_err_d = 1'b1;
          end
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      GRANT: begin
        if (hold_cnt_q < HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
        // A voluntary release in the same cycle as a timeout is not a preemption.
        if (!owner_req || timeout) begin
          grant_d            = {NO_MASTERS{1'b0}};
          bus_state_d        = {owner, SID_NONE};
          preempt_d[owner]   = owner_req;
        end else begin
          grant_d = grant_q;
        end
      end
      RELEASE: begin
        grant_d     = {NO_MASTERS{1'b0}};
        bus_state_d = {owner, SID_NONE};
      end
      default: begin
        grant_d     = {NO_MASTERS{1'b0}};
        bus_state_d = {BS_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, 3 slaves, MAX_HOLD=4) with
// hand-computed expectations on grant, bus_state, preempt and req_err.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req_M      [0:1];
  logic [1:0] slave_id_M [0:1];
  logic       ready;
  logic       grant_M    [0:1];
  logic       preempt_M  [0:1];
  logic [2:0] bus_state;
  logic       req_err;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(
    .NO_MASTERS (2),
    .NO_SLAVES  (3),
    .MAX_HOLD   (4)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .req_M      (req_M),
    .slave_id_M (slave_id_M),
    .ready      (ready),
    .grant_M    (grant_M),
    .preempt_M  (preempt_M),
    .bus_state  (bus_state),
    .req_err    (req_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // eg = {grant_M[1], grant_M[0]}, ep = {preempt_M[1], preempt_M[0]}
  task automatic chk(input string tag, input logic [1:0] eg, input logic [2:0] ebs,
                     input logic [1:0] ep, input logic ee);
    logic [7:0] obs;
    logic [7:0] exp_v;
    obs   = {grant_M[1], grant_M[0], bus_state, preempt_M[1], preempt_M[0], req_err};
    exp_v = {eg, ebs, ep, ee};
    checks++;
    assert (obs === exp_v)
      else begin
        failures++;
        $error("FAIL %s observed={g,bs,p,err}=%b expected=%b", tag, obs, exp_v);
      end
  endtask

  initial begin
    rstN = 1'b0;
    req_M[0] = 1'b0; req_M[1] = 1'b0;
    slave_id_M[0] = 2'd0; slave_id_M[1] = 2'd0;
    ready = 1'b1;
    step();
    step();
    chk("reset", 2'b00, 3'b000, 2'b00, 1'b0);

    // Single request from M0 to slave 2
    rstN = 1'b1;
    req_M[0] = 1'b1; slave_id_M[0] = 2'd2;
    step(); chk("single_grant", 2'b01, 3'b010, 2'b00, 1'b0);
    step(); chk("single_hold", 2'b01, 3'b010, 2'b00, 1'b0);
    req_M[0] = 1'b0;
    step(); chk("single_release", 2'b00, 3'b000, 2'b00, 1'b0);
    step(); chk("single_idle", 2'b00, 3'b000, 2'b00, 1'b0);

    // Contention from reset: M0 first, then M1 after release + idle
    rstN = 1'b0;
    req_M[0] = 1'b1; req_M[1] = 1'b1;
    slave_id_M[0] = 2'd1; slave_id_M[1] = 2'd3;
    step(); chk("cont_reset", 2'b00, 3'b000, 2'b00, 1'b0);
    rstN = 1'b1;
    step(); chk("cont_m0_first", 2'b01, 3'b001, 2'b00, 1'b0);
    req_M[0] = 1'b0;
    step(); chk("cont_release", 2'b00, 3'b000, 2'b00, 1'b0);
    step(); chk("cont_idle", 2'b00, 3'b000, 2'b00, 1'b0);
    step(); chk("cont_m1_grant", 2'b10, 3'b111, 2'b00, 1'b0);

    // Fairness: both requesting, owners alternate with a preempt after 4 cycles
    req_M[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("fair_m1_hold%0d", i), 2'b10, 3'b111, 2'b00, 1'b0);
    end
    step(); chk("fair_m1_preempt", 2'b00, 3'b100, 2'b10, 1'b0);
    step(); chk("fair_idle_a", 2'b00, 3'b100, 2'b00, 1'b0);
    step(); chk("fair_m0_grant", 2'b01, 3'b001, 2'b00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("fair_m0_hold%0d", i), 2'b01, 3'b001, 2'b00, 1'b0);
    end
    step(); chk("fair_m0_preempt", 2'b00, 3'b000, 2'b01, 1'b0);
    step(); chk("fair_idle_b", 2'b00, 3'b000, 2'b00, 1'b0);
    step(); chk("fair_m1_regrant", 2'b10, 3'b111, 2'b00, 1'b0);

    // Preemption postponed while ready is low
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("rdy_hold%0d", i), 2'b10, 3'b111, 2'b00, 1'b0);
    end
    ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("rdy_wait%0d", i), 2'b10, 3'b111, 2'b00, 1'b0);
    end
    ready = 1'b1;
    step(); chk("rdy_preempt", 2'b00, 3'b100, 2'b10, 1'b0);
    req_M[0] = 1'b0; req_M[1] = 1'b0;
    step(); chk("rdy_idle", 2'b00, 3'b100, 2'b00, 1'b0);

    // Invalid slave id on M1: error pulse, no grant, M0 served next
    req_M[1] = 1'b1; slave_id_M[1] = 2'd0;
    step(); chk("inv_err", 2'b00, 3'b100, 2'b00, 1'b1);
    req_M[0] = 1'b1; slave_id_M[0] = 2'd2;
    step(); chk("inv_m0_grant", 2'b01, 3'b010, 2'b00, 1'b0);
    req_M[0] = 1'b0; req_M[1] = 1'b0; slave_id_M[1] = 2'd3;
    step(); chk("inv_release", 2'b00, 3'b000, 2'b00, 1'b0);
    step(); chk("inv_idle", 2'b00, 3'b000, 2'b00, 1'b0);

    // Reset in the middle of a grant, then M0 has first priority
    req_M[1] = 1'b1;
    step(); chk("rst_m1_grant", 2'b10, 3'b111, 2'b00, 1'b0);
    rstN = 1'b0;
    req_M[0] = 1'b1; slave_id_M[0] = 2'd1;
    step(); chk("rst_mid_grant", 2'b00, 3'b000, 2'b00, 1'b0);
    rstN = 1'b1;
    step(); chk("rst_m0_first", 2'b01, 3'b001, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
